ft600_dev_model: RTL and testbench
==================================

// Module: ft600_dev_model
// PURPOSE
//  Synthesizable model of the FT600 device side of the 245 sync FIFO bus: the
//  responder to our FPGA-side FT600 master FSM. Holds an RX buffer (host->FPGA,
//  read by the master) and a TX buffer (FPGA->host, written by the master), and
//  drives rxf_n/txe_n from buffer occupancy. Host-side valid/ready ports on clk.
//  Used for loopback bring-up on a second FPGA and as the bench BFM.
// PARAMETERS
//  FT_DATA_WIDTH   32  ft_data width; ft_be is FT_DATA_WIDTH/8 bits
//  RX_DEPTH_LOG2   10  RX buffer depth 2**N words (1024 words = 4 KB)
//  TX_DEPTH_LOG2   10  TX buffer depth 2**N words
// PORTS
//  clk         in   1    bus clock; all logic on posedge
//  reset_n     in   1    asynchronous, active-low reset
//  rxf_n       out  1    0 = RX buffer non-empty
//  txe_n       out  1    0 = TX buffer has at least one free word
//  oe_n        in   1    0 = device drives ft_data/ft_be
//  rd_n        in   1    0 = master pops one RX word per clk
//  wr_n        in   1    0 = master pushes one TX word per clk
//  ft_data     inout FT_DATA_WIDTH  bidirectional data
//  ft_be       inout FT_DATA_WIDTH/8 bidirectional byte enables
//  h_rx_valid/h_rx_ready  in/out 1  host push into RX buffer
//  h_rx_data/h_rx_be      in  W/W/8 host push payload
//  h_tx_valid/h_tx_ready  out/in 1  host pop from TX buffer
//  h_tx_data/h_tx_be      out W/W/8 TX head word (first-word-fall-through)
//  rx_level/tx_level      out N+1   occupancy in words
//  overflow/underrun/proto_err out 1 sticky error flags
//  clr_err     in   1    synchronous clear of all sticky error flags
// BEHAVIOUR
//  Reset: rxf_n=1, txe_n=1, levels 0, error flags 0, bus state IDLE, ft_data/ft_be
//   Z. On the first posedge after release: txe_n=0, rxf_n=1.
//  Flags are registered from post-edge occupancy: rxf_n = (rx_level==0),
//   txe_n = (tx_level==2**TX_DEPTH_LOG2). A flag changes on the edge that changes the level.
//  Bus drive: ft_data/ft_be = RX head word/be while oe_n==0, else Z. Combinational
//   from oe_n; no turnaround cycle is inserted.
//  RX pop: posedge with rd_n==0 & oe_n==0 & rx_level!=0 -> read pointer ++.
//   Master samples the head word at that same edge. rd_n==0 with rx_level==0 ->
//   underrun=1, pointer and level unchanged, bus shows stale word at pointer.
//  TX push: posedge with wr_n==0 & oe_n==1 -> capture ft_data/ft_be if pre-edge
//   tx_level<depth. If full, drop the word and set overflow=1, even if the host pops on the same edge.
//  Host RX push: h_rx_ready = (rx_level!=depth); write on valid&ready.
//  Host TX pop: h_tx_valid = (tx_level!=0); advance on valid&ready.
//  Simultaneous push+pop on one buffer: level unchanged. Pointers wrap modulo
//   depth. Level is N+1 bits, so full and empty are distinct.
//  Bus FSM (monitor, drives proto_err): IDLE -> RX on oe_n==0; IDLE -> TX on
//   wr_n==0 & oe_n==1; RX -> IDLE on oe_n==1; TX -> IDLE on wr_n==1.
//  proto_err=1 on any edge with (wr_n==0 & oe_n==0), (rd_n==0 & oe_n==1), or
//   (rd_n==0 & wr_n==0). The offending strobe is ignored; the buffer does not change.
//  clr_err==1: all sticky flags 0 on that edge. Clear wins over a new set on the same edge.
//  Reset mid-burst: buffers emptied, in-flight word discarded, bus to Z at once.
// TESTING
//  T1 reset: check Z bus and flags=1. Release -> 1 clk later txe_n=0, rxf_n=1, levels 0.
//  T2 host pushes 0xA0000001..0xA0000003 (be=F) -> rxf_n=0 next edge. Master oe_n=0,
//     rd_n=0 for 3 clk -> samples A..1,2,3 in order; rxf_n=1 after the 3rd edge; underrun=0.
//  T3 TX_DEPTH_LOG2=2, master writes 5 words 0x1..0x5 -> txe_n=1 after 4th edge,
//     word 5 dropped, overflow=1. Host pops 0x1..0x4.
//  T4 TX full, host pop and master write on the same edge -> write dropped, level=3,
//     overflow=1. Next edge write accepted -> level=4.
//  T5 rx_level=0, oe_n=0, rd_n=0 for 2 clk -> underrun=1, rx_level stays 0.
//     clr_err pulse -> underrun=0.
//  T6 oe_n=0 with wr_n=0 on data 0xDEADBEEF -> proto_err=1, tx_level unchanged.
//     Assert reset mid-T2 burst -> levels 0 and bus Z immediately.

Source files
------------

// File: rtl/ft600_dev_model.sv
// Device-side model of the FT600 245 sync FIFO bus: RX/TX word buffers,
// occupancy-driven rxf_n/txe_n, host valid/ready ports and a bus protocol monitor.
module ft600_dev_model #(
   parameter int FT_DATA_WIDTH = 32,
   parameter int RX_DEPTH_LOG2 = 10,
   parameter int TX_DEPTH_LOG2 = 10
) (
   input  logic                          clk,
   input  logic                          reset_n,
   output logic                          rxf_n,
   output logic                          txe_n,
   input  logic                          oe_n,
   input  logic                          rd_n,
   input  logic                          wr_n,
   inout  wire  [FT_DATA_WIDTH-1:0]      ft_data,
   inout  wire  [FT_DATA_WIDTH/8-1:0]    ft_be,
   input  logic                          h_rx_valid,
   output logic                          h_rx_ready,
   input  logic [FT_DATA_WIDTH-1:0]      h_rx_data,
   input  logic [FT_DATA_WIDTH/8-1:0]    h_rx_be,
   output logic                          h_tx_valid,
   input  logic                          h_tx_ready,
   output logic [FT_DATA_WIDTH-1:0]      h_tx_data,
   output logic [FT_DATA_WIDTH/8-1:0]    h_tx_be,
   output logic [RX_DEPTH_LOG2:0]        rx_level,
   output logic [TX_DEPTH_LOG2:0]        tx_level,
   output logic                          overflow,
   output logic                          underrun,
   output logic                          proto_err,
   input  logic                          clr_err
);
   localparam int DW  = FT_DATA_WIDTH;
   localparam int BW  = FT_DATA_WIDTH / 8;
   localparam int RAW = RX_DEPTH_LOG2;
   localparam int TAW = TX_DEPTH_LOG2;
   localparam logic [RAW:0] RX_FULL = {1'b1, {RAW{1'b0}}};
   localparam logic [TAW:0] TX_FULL = {1'b1, {TAW{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RX, S_TX} bus_state_e;

   logic [DW-1:0]  rx_data_mem [2**RAW];
   logic [BW-1:0]  rx_be_mem   [2**RAW];
   logic [DW-1:0]  tx_data_mem [2**TAW];
   logic [BW-1:0]  tx_be_mem   [2**TAW];

   logic [RAW-1:0] rx_wr_q, rx_rd_q;
   logic [TAW-1:0] tx_wr_q, tx_rd_q;
   logic [RAW:0]   rx_level_q, rx_level_d;
   logic [TAW:0]   tx_level_q, tx_level_d;
   logic           rxf_n_q, txe_n_q, ovf_q, und_q, perr_q;
   bus_state_e     state_q;

   logic proto_bad, rx_push, rx_pop, tx_wr, tx_push, tx_pop;

   // A strobe combined with the wrong oe_n/strobe is a protocol error and is ignored.
   assign proto_bad = (!wr_n && !oe_n) || (!rd_n && oe_n) || (!rd_n && !wr_n);
   assign rx_pop    = !rd_n && !oe_n && wr_n && (rx_level_q != '0);
   assign tx_wr     = !wr_n && oe_n && rd_n;
   assign tx_push   = tx_wr && (tx_level_q != TX_FULL);
   assign rx_push   = h_rx_valid && h_rx_ready;
   assign tx_pop    = h_tx_valid && h_tx_ready;

   assign h_rx_ready = (rx_level_q != RX_FULL);
   assign h_tx_valid = (tx_level_q != '0);
   assign h_tx_data  = tx_data_mem[tx_rd_q];
   assign h_tx_be    = tx_be_mem[tx_rd_q];
   assign rx_level   = rx_level_q;
   assign tx_level   = tx_level_q;
   assign rxf_n      = rxf_n_q;
   assign txe_n      = txe_n_q;
   assign overflow   = ovf_q;
   assign underrun   = und_q;
   assign proto_err  = perr_q;

   // Reset gates the drive directly so the bus floats the moment reset asserts.
   assign ft_data = (reset_n && !oe_n) ? rx_data_mem[rx_rd_q] : {DW{1'bz}};
   assign ft_be   = (reset_n && !oe_n) ? rx_be_mem[rx_rd_q]   : {BW{1'bz}};

   always_comb begin
      rx_level_d = rx_level_q;
      if (rx_push && !rx_pop)      rx_level_d = rx_level_q + (RAW+1)'(1);
      else if (!rx_push && rx_pop) rx_level_d = rx_level_q - (RAW+1)'(1);
      tx_level_d = tx_level_q;
      if (tx_push && !tx_pop)      tx_level_d = tx_level_q + (TAW+1)'(1);
      else if (!tx_push && tx_pop) tx_level_d = tx_level_q - (TAW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rx_push) begin
         rx_data_mem[rx_wr_q] <= h_rx_data;
         rx_be_mem[rx_wr_q]   <= h_rx_be;
      end
      if (tx_push) begin
         tx_data_mem[tx_wr_q] <= ft_data;
         tx_be_mem[tx_wr_q]   <= ft_be;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         rx_level_q <= '0;
         tx_level_q <= '0;
         rxf_n_q    <= 1'b1;
         txe_n_q    <= 1'b1;
         ovf_q      <= 1'b0;
         und_q      <= 1'b0;
         perr_q     <= 1'b0;
         state_q    <= S_IDLE;
      end else begin
         if (rx_push) rx_wr_q <= rx_wr_q + RAW'(1);
         if (rx_pop)  rx_rd_q <= rx_rd_q + RAW'(1);
         if (tx_push) tx_wr_q <= tx_wr_q + TAW'(1);
         if (tx_pop)  tx_rd_q <= tx_rd_q + TAW'(1);
         rx_level_q <= rx_level_d;
         tx_level_q <= tx_level_d;
         rxf_n_q    <= (rx_level_d == '0);
         txe_n_q    <= (tx_level_d == TX_FULL);
         // Clear takes priority over any error raised on the same edge.
         if (clr_err) begin
            ovf_q  <= 1'b0;
            und_q  <= 1'b0;
            perr_q <= 1'b0;
         end else begin
            if (tx_wr && (tx_level_q == TX_FULL)) ovf_q  <= 1'b1;
            if (!rd_n && (rx_level_q == '0))      und_q  <= 1'b1;
            if (proto_bad)                        perr_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: if (!oe_n)              state_q <= S_RX;
                    else if (!wr_n)         state_q <= S_TX;
            S_RX:   if (oe_n)               state_q <= S_IDLE;
            S_TX:   if (wr_n)               state_q <= S_IDLE;
            default:                        state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ft600_dev_model.sv
// Directed bench for ft600_dev_model: scoreboard queues hold the words each buffer must return.
module tb_ft600_dev_model;
   localparam int DW = 32;
   localparam int RAW = 3;
   localparam int TAW = 2;

   logic clk, reset_n, oe_n, rd_n, wr_n, clr_err;
   logic rxf_n, txe_n, overflow, underrun, proto_err;
   logic h_rx_valid, h_rx_ready, h_tx_valid, h_tx_ready;
   logic [DW-1:0] h_rx_data, h_tx_data, tb_data;
   logic [3:0] h_rx_be, h_tx_be, tb_be;
   logic [RAW:0] rx_level;
   logic [TAW:0] tx_level;
   logic tb_drv;
   tri1 [DW-1:0] ft_data;
   tri1 [3:0] ft_be;

   assign ft_data = tb_drv ? tb_data : 'z;
   assign ft_be   = tb_drv ? tb_be   : 'z;

   int total = 0;
   int bad = 0;
   logic [DW-1:0] rx_q[$];
   logic [DW-1:0] tx_q[$];
   logic [DW-1:0] exp_w;
   int mdl_lvl;

   ft600_dev_model #(.FT_DATA_WIDTH(DW), .RX_DEPTH_LOG2(RAW), .TX_DEPTH_LOG2(TAW)) dut (
      .clk(clk), .reset_n(reset_n), .rxf_n(rxf_n), .txe_n(txe_n),
      .oe_n(oe_n), .rd_n(rd_n), .wr_n(wr_n), .ft_data(ft_data), .ft_be(ft_be),
      .h_rx_valid(h_rx_valid), .h_rx_ready(h_rx_ready), .h_rx_data(h_rx_data), .h_rx_be(h_rx_be),
      .h_tx_valid(h_tx_valid), .h_tx_ready(h_tx_ready), .h_tx_data(h_tx_data), .h_tx_be(h_tx_be),
      .rx_level(rx_level), .tx_level(tx_level), .overflow(overflow), .underrun(underrun),
      .proto_err(proto_err), .clr_err(clr_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 0; oe_n = 1; rd_n = 1; wr_n = 1; clr_err = 0; tb_drv = 0;
      tb_data = '0; tb_be = '0; h_rx_valid = 0; h_rx_data = '0; h_rx_be = '0; h_tx_ready = 0;

      // T1: reset state, bus floats even with oe_n low
      step(); step();
      oe_n = 0;
      @(negedge clk);
      chk("rst_bus_z", ft_data, 64'hFFFF_FFFF);
      chk("rst_be_z", ft_be, 64'hF);
      chk("rst_rxf", rxf_n, 1);
      chk("rst_txe", txe_n, 1);
      chk("rst_rxlvl", rx_level, 0);
      oe_n = 1;
      step();
      reset_n = 1;
      @(negedge clk);
      chk("rel_txe_hold", txe_n, 1);
      step();
      @(negedge clk);
      chk("rel_txe", txe_n, 0);
      chk("rel_rxf", rxf_n, 1);
      chk("rel_txlvl", tx_level, 0);
      chk("rel_errs", {overflow, underrun, proto_err}, 0);
      step();

      // T2: host fills RX, master bursts it out
      for (int i = 0; i < 3; i++) begin
         h_rx_valid = 1; h_rx_data = 32'hA000_0001 + i; h_rx_be = 4'hF;
         rx_q.push_back(h_rx_data);
         @(negedge clk);
         chk("rx_ready", h_rx_ready, 1);
         step();
         if (i == 0) chk("rxf_after_push", rxf_n, 0);
      end
      h_rx_valid = 0;
      chk("rx_lvl3", rx_level, 3);
      oe_n = 0; rd_n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_w = rx_q.pop_front();
         chk("rd_data", ft_data, exp_w);
         chk("rd_be", ft_be, 4'hF);
         step();
      end
      chk("rxf_empty", rxf_n, 1);
      rd_n = 1; oe_n = 1;
      chk("rx_lvl0", rx_level, 0);
      chk("no_underrun", underrun, 0);
      chk("no_proto", proto_err, 0);

      // T3: master overfills TX, host drains
      tb_drv = 1; wr_n = 0; tb_be = 4'hF; mdl_lvl = 0;
      for (int i = 1; i <= 5; i++) begin
         tb_data = i;
         if (mdl_lvl < 4) begin tx_q.push_back(tb_data); mdl_lvl++; end
         if (i == 5) begin @(negedge clk); chk("txe_full", txe_n, 1); end
         step();
      end
      wr_n = 1; tb_drv = 0;
      chk("ovf_set", overflow, 1);
      chk("tx_lvl4", tx_level, 4);
      h_tx_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tx_valid", h_tx_valid, 1);
         exp_w = tx_q.pop_front();
         chk("tx_data", h_tx_data, exp_w);
         chk("tx_be", h_tx_be, 4'hF);
         step();
      end
      h_tx_ready = 0;
      chk("tx_lvl0", tx_level, 0);
      chk("tx_valid0", h_tx_valid, 0);
      chk("txe_free", txe_n, 0);
      clr_err = 1; step(); clr_err = 0;
      chk("ovf_clr", overflow, 0);

      // T4: write on full with simultaneous host pop is dropped
      tb_drv = 1; wr_n = 0;
      for (int i = 0; i < 4; i++) begin
         tb_data = 32'h11 + i;
         tx_q.push_back(tb_data);
         step();
      end
      chk("t4_full", tx_level, 4);
      tb_data = 32'h15; h_tx_ready = 1;
      @(negedge clk);
      exp_w = tx_q.pop_front();
      chk("t4_pop", h_tx_data, exp_w);
      step();
      chk("t4_lvl3", tx_level, 3);
      chk("t4_ovf", overflow, 1);
      chk("t4_txe", txe_n, 0);
      h_tx_ready = 0; tb_data = 32'h16;
      tx_q.push_back(tb_data);
      step();
      chk("t4_lvl4", tx_level, 4);
      wr_n = 1; tb_drv = 0;
      h_tx_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_w = tx_q.pop_front();
         chk("t4_drain", h_tx_data, exp_w);
         step();
      end
      h_tx_ready = 0;

      // T5: underrun on empty RX, then clear (and clear beats a same-edge set)
      oe_n = 0; rd_n = 0;
      step(); step();
      rd_n = 1; oe_n = 1;
      chk("und_set", underrun, 1);
      chk("und_lvl", rx_level, 0);
      chk("und_rxf", rxf_n, 1);
      clr_err = 1; step(); clr_err = 0;
      chk("und_clr", underrun, 0);
      chk("ovf_clr2", overflow, 0);
      oe_n = 0; rd_n = 0; clr_err = 1;
      step();
      clr_err = 0; oe_n = 1; rd_n = 1;
      chk("clr_wins", underrun, 0);

      // T6: protocol errors leave buffers untouched
      oe_n = 0; wr_n = 0; tb_data = 32'hDEAD_BEEF;
      step();
      wr_n = 1; oe_n = 1;
      chk("perr_wr_oe", proto_err, 1);
      chk("perr_txlvl", tx_level, 0);
      clr_err = 1; step(); clr_err = 0;
      chk("perr_clr", proto_err, 0);
      h_rx_valid = 1; h_rx_data = 32'hB000_0001; h_rx_be = 4'hF;
      rx_q.push_back(h_rx_data);
      step();
      h_rx_valid = 0;
      rd_n = 0;
      step();
      rd_n = 1;
      chk("perr_rd_nooe", proto_err, 1);
      chk("perr_rxlvl", rx_level, 1);

      // Reset in the middle of a read burst
      for (int i = 0; i < 3; i++) begin
         h_rx_valid = 1; h_rx_data = 32'hA000_0001 + i;
         rx_q.push_back(h_rx_data);
         step();
      end
      h_rx_valid = 0;
      tb_drv = 1; wr_n = 0; tb_data = 32'h77;
      step();
      wr_n = 1; tb_drv = 0;
      oe_n = 0; rd_n = 0;
      @(negedge clk);
      exp_w = rx_q.pop_front();
      chk("mid_rd", ft_data, exp_w);
      step();
      reset_n = 0;
      #1;
      chk("mid_bus_z", ft_data, 64'hFFFF_FFFF);
      chk("mid_rxlvl", rx_level, 0);
      chk("mid_txlvl", tx_level, 0);
      chk("mid_rxf", rxf_n, 1);
      rx_q.delete();
      rd_n = 1; oe_n = 1;
      step();
      reset_n = 1;
      step(); step();
      chk("post_txe", txe_n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
